// File: rtl/fwperiph_dma_wb_ctrl.sv
// rtl/fwperiph_dma_wb_ctrl.sv - Four-channel Wishbone DMA controller sharing one word-transfer engine
// Optional macro FWPERIPH_DMA_DBG_EN maps {active channel, engine state} into DBG (0x14).
module fwperiph_dma_wb_ctrl #(
    parameter int         ch_count = 4,
    parameter logic [3:0] ch0_conf = 4'hF,
    parameter logic [3:0] ch1_conf = 4'hF,
    parameter logic [3:0] ch2_conf = 4'hF,
    parameter logic [3:0] ch3_conf = 4'hF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] rt_adr,
    input  logic [31:0] rt_dat_w,
    output logic [31:0] rt_dat_r,
    input  logic        rt_cyc,
    input  logic        rt_stb,
    input  logic        rt_we,
    input  logic [3:0]  rt_sel,
    output logic        rt_ack,
    output logic        rt_err,
    output logic [31:0] i0_adr,
    output logic [31:0] i0_dat_w,
    input  logic [31:0] i0_dat_r,
    output logic        i0_cyc,
    output logic        i0_stb,
    output logic        i0_we,
    output logic [3:0]  i0_sel,
    input  logic        i0_ack,
    input  logic        i0_err,
    output logic [31:0] i1_adr,
    output logic [31:0] i1_dat_w,
    input  logic [31:0] i1_dat_r,
    output logic        i1_cyc,
    output logic        i1_stb,
    output logic        i1_we,
    output logic [3:0]  i1_sel,
    input  logic        i1_ack,
    input  logic        i1_err,
    input  logic [3:0]  dma_req_i,
    output logic [3:0]  dma_ack_o,
    input  logic [3:0]  dma_nd_i,
    input  logic [3:0]  dma_rest_i,
    output logic        inta_o,
    output logic        intb_o
);
    typedef enum logic [2:0] {IDLE = 3'd0, RD = 3'd1, GAP = 3'd2, WR = 3'd3, NEXT = 3'd4} state_t;

    state_t      state;
    logic [1:0]  act, win, rch;
    logic        any, hit, ch_hit, csr_en, bus_cyc, bus_we, bus_if, bus_ack, bus_err, nd_eff;
    logic [31:0] bus_adr, data_q, rdata, dbg, bus_rdat;
    logic [8:0]  chunk_cnt;
    logic [3:0]  msk_a, msk_b, int_src, done, err_f, nd_seen, ch_ok, elig, busy;
    logic [3:0]  conf_v [4];
    logic [7:0]  ctl [4];
    logic [7:0]  csr_mask [4];
    logic [11:0] sz_tot [4], sh_tot [4], rem [4];
    logic [8:0]  sz_chunk [4], sh_chunk [4];
    logic [31:0] src [4], dst [4], sh_src [4], sh_dst [4], cur_src [4], cur_dst [4];
    logic        unused;

    assign conf_v = '{ch0_conf, ch1_conf, ch2_conf, ch3_conf};

    // CIRC and ARS bits only stick when the channel configuration allows them
    for (genvar g = 0; g < 4; g++) begin : g_ch
        assign ch_ok[g]    = (g < ch_count) && conf_v[g][0];
        assign csr_mask[g] = {conf_v[g][3], 2'b11, conf_v[g][1], 4'hF};
        assign elig[g]     = ch_ok[g] && ctl[g][0] && csr_en && (rem[g] != 12'd0)
                             && (!ctl[g][3] || dma_req_i[g]);
        assign busy[g]     = (state != IDLE) && (act == g);
    end

    always_comb begin
        win = 2'd0;
        any = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (elig[i]) begin
                win = 2'(i);
                any = 1'b1;
            end
        end
    end

    assign hit    = rt_cyc && rt_stb && !rt_ack;
    assign rch    = 2'(rt_adr[7:5] - 3'd1);
    assign ch_hit = (rt_adr[31:8] == 24'd0) && (rt_adr[7:5] != 3'd0) && (rt_adr[7:5] <= 3'd4) && ch_ok[rch];
    assign nd_eff = nd_seen[act] || (dma_nd_i[act] && conf_v[act][2]);

`ifdef FWPERIPH_DMA_DBG_EN
    assign dbg = {26'd0, act, 1'b0, state};
`else
    assign dbg = 32'd0;
`endif

    always_comb begin
        rdata = 32'd0;
        if (ch_hit) begin
            case (rt_adr[4:2])
                3'd0:    rdata = {21'd0, busy[rch], err_f[rch], done[rch], ctl[rch]};
                3'd1:    rdata = {7'd0, sz_chunk[rch], 4'd0, sz_tot[rch]};
                3'd2:    rdata = src[rch];
                3'd3:    rdata = dst[rch];
                default: rdata = 32'd0;
            endcase
        end else if (rt_adr[31:8] == 24'd0) begin
            case (rt_adr[7:0])
                8'h00:   rdata = {31'd0, csr_en};
                8'h04:   rdata = {28'd0, msk_a};
                8'h08:   rdata = {28'd0, msk_b};
                8'h0C:   rdata = {28'd0, int_src};
                8'h14:   rdata = dbg;
                default: rdata = 32'd0;
            endcase
        end
    end

    assign bus_ack  = bus_if ? i1_ack : i0_ack;
    assign bus_err  = bus_if ? i1_err : i0_err;
    assign bus_rdat = bus_if ? i1_dat_r : i0_dat_r;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;      act <= 2'd0;       chunk_cnt <= 9'd0;
            bus_cyc <= 1'b0;    bus_we <= 1'b0;    bus_if <= 1'b0;
            bus_adr <= 32'd0;   data_q <= 32'd0;
            rt_ack <= 1'b0;     rt_dat_r <= 32'd0; csr_en <= 1'b0;
            msk_a <= 4'd0;      msk_b <= 4'd0;     int_src <= 4'd0;
            inta_o <= 1'b0;     intb_o <= 1'b0;    dma_ack_o <= 4'd0;
            done <= 4'd0;       err_f <= 4'd0;     nd_seen <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                ctl[i] <= 8'd0;     sz_tot[i] <= 12'd0;  sz_chunk[i] <= 9'd0;
                src[i] <= 32'd0;    dst[i] <= 32'd0;     sh_tot[i] <= 12'd0;
                sh_chunk[i] <= 9'd0; sh_src[i] <= 32'd0; sh_dst[i] <= 32'd0;
                rem[i] <= 12'd0;    cur_src[i] <= 32'd0; cur_dst[i] <= 32'd0;
            end
        end else begin
            rt_ack    <= hit;
            dma_ack_o <= 4'd0;
            inta_o    <= |(int_src & msk_a);
            intb_o    <= |(int_src & msk_b);
            if (hit) rt_dat_r <= rdata;

            if (hit && rt_we) begin
                if (ch_hit) begin
                    case (rt_adr[4:2])
                        3'd0: begin
                            ctl[rch] <= rt_dat_w[7:0] & csr_mask[rch];
                            if (rt_dat_w[0]) begin
                                done[rch] <= 1'b0;          err_f[rch] <= 1'b0;
                                sh_tot[rch] <= sz_tot[rch]; sh_chunk[rch] <= sz_chunk[rch];
                                sh_src[rch] <= src[rch];    sh_dst[rch] <= dst[rch];
                                rem[rch] <= sz_tot[rch];    cur_src[rch] <= src[rch];
                                cur_dst[rch] <= dst[rch];
                            end
                        end
                        3'd1: begin
                            sz_tot[rch]   <= rt_dat_w[11:0];
                            sz_chunk[rch] <= rt_dat_w[24:16];
                        end
                        3'd2:    src[rch] <= {rt_dat_w[31:2], 2'b00};
                        3'd3:    dst[rch] <= {rt_dat_w[31:2], 2'b00};
                        default: ;
                    endcase
                end else if (rt_adr[31:8] == 24'd0) begin
                    case (rt_adr[7:0])
                        8'h00:   csr_en <= rt_dat_w[0];
                        8'h04:   msk_a <= rt_dat_w[3:0];
                        8'h08:   msk_b <= rt_dat_w[3:0];
                        8'h0C:   int_src <= int_src & ~rt_dat_w[3:0];
                        default: ;
                    endcase
                end
            end

            for (int i = 0; i < 4; i++) begin
                if (dma_rest_i[i] && ch_ok[i] && !busy[i]) begin
                    ctl[i][0] <= 1'b1;       rem[i] <= sh_tot[i];
                    cur_src[i] <= sh_src[i]; cur_dst[i] <= sh_dst[i];
                end
                if (busy[i] && dma_nd_i[i] && conf_v[i][2]) nd_seen[i] <= 1'b1;
            end

            // Engine updates come last so they win over a colliding register write
            if ((state == RD || state == WR) && bus_err) begin
                bus_cyc <= 1'b0;      bus_we <= 1'b0;
                err_f[act] <= 1'b1;   int_src[act] <= 1'b1;
                ctl[act][0] <= 1'b0;  state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (any) begin
                        act <= win;
                        chunk_cnt <= (sh_chunk[win] == 9'd0) ? 9'd1 : sh_chunk[win];
                        nd_seen[win] <= 1'b0;
                        bus_cyc <= 1'b1;  bus_we <= 1'b0;
                        bus_if <= ctl[win][1];  bus_adr <= cur_src[win];
                        state <= RD;
                    end
                    RD: if (bus_ack) begin
                        data_q <= bus_rdat;  bus_cyc <= 1'b0;  state <= GAP;
                    end
                    GAP: begin
                        bus_cyc <= 1'b1;  bus_we <= 1'b1;
                        bus_if <= ctl[act][2];  bus_adr <= cur_dst[act];
                        state <= WR;
                    end
                    WR: if (bus_ack) begin
                        bus_cyc <= 1'b0;  bus_we <= 1'b0;  state <= NEXT;
                    end
                    NEXT: begin
                        if (ctl[act][5]) cur_src[act] <= cur_src[act] + 32'd4;
                        if (ctl[act][6]) cur_dst[act] <= cur_dst[act] + 32'd4;
                        rem[act]  <= rem[act] - 12'd1;
                        chunk_cnt <= chunk_cnt - 9'd1;
                        if (!ctl[act][0]) begin
                            state <= IDLE;
                        end else if (rem[act] == 12'd1 || chunk_cnt == 9'd1 || nd_eff) begin
                            state <= IDLE;
                            if (ctl[act][3]) dma_ack_o[act] <= 1'b1;
                            if (nd_eff) begin
                                done[act] <= 1'b1;  int_src[act] <= 1'b1;  ctl[act][0] <= 1'b0;
                            end else if (rem[act] == 12'd1) begin
                                done[act] <= 1'b1;  int_src[act] <= 1'b1;
                                if (ctl[act][7] || ctl[act][4]) begin
                                    rem[act] <= sh_tot[act];
                                    cur_src[act] <= sh_src[act];
                                    cur_dst[act] <= sh_dst[act];
                                end else begin
                                    ctl[act][0] <= 1'b0;
                                end
                            end
                        end else begin
                            bus_cyc <= 1'b1;  bus_we <= 1'b0;  bus_if <= ctl[act][1];
                            bus_adr <= ctl[act][5] ? cur_src[act] + 32'd4 : cur_src[act];
                            state <= RD;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign rt_err   = 1'b0;
    assign i0_cyc   = bus_cyc && !bus_if;
    assign i0_stb   = bus_cyc && !bus_if;
    assign i0_we    = bus_we && !bus_if;
    assign i0_adr   = bus_adr;
    assign i0_dat_w = data_q;
    assign i0_sel   = 4'hF;
    assign i1_cyc   = bus_cyc && bus_if;
    assign i1_stb   = bus_cyc && bus_if;
    assign i1_we    = bus_we && bus_if;
    assign i1_adr   = bus_adr;
    assign i1_dat_w = data_q;
    assign i1_sel   = 4'hF;
    assign unused   = ^{rt_sel, rt_adr[1:0], rt_dat_w[15:12]};
endmodule

// File: tb/tb_fwperiph_dma_wb_ctrl.sv
// tb/tb_fwperiph_dma_wb_ctrl.sv - Directed self-checking bench for fwperiph_dma_wb_ctrl
module tb_fwperiph_dma_wb_ctrl;
    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] rt_adr = 32'd0, rt_dat_w = 32'd0, rt_dat_r;
    logic        rt_cyc = 1'b0, rt_stb = 1'b0, rt_we = 1'b0, rt_ack, rt_err;
    logic [3:0]  rt_sel = 4'hF;
    logic [31:0] i0_adr, i0_dat_w, i0_dat_r, i1_adr, i1_dat_w, i1_dat_r;
    logic        i0_cyc, i0_stb, i0_we, i1_cyc, i1_stb, i1_we;
    logic [3:0]  i0_sel, i1_sel;
    logic        i0_ack = 1'b0, i0_err = 1'b0, i1_ack = 1'b0, i1_err = 1'b0;
    logic [3:0]  dma_req_i = 4'd0, dma_ack_o, dma_nd_i = 4'd0, dma_rest_i = 4'd0;
    logic        inta_o, intb_o;
    logic        err_rd0 = 1'b0;
    int          checks = 0, errors = 0;

    typedef struct {bit ifc; bit we; logic [31:0] adr; logic [31:0] dat;} xact_t;
    xact_t log_q[$];

    always #5 clk = ~clk;

    fwperiph_dma_wb_ctrl dut (
        .clock(clk), .reset(rst),
        .rt_adr(rt_adr), .rt_dat_w(rt_dat_w), .rt_dat_r(rt_dat_r), .rt_cyc(rt_cyc),
        .rt_stb(rt_stb), .rt_we(rt_we), .rt_sel(rt_sel), .rt_ack(rt_ack), .rt_err(rt_err),
        .i0_adr(i0_adr), .i0_dat_w(i0_dat_w), .i0_dat_r(i0_dat_r), .i0_cyc(i0_cyc),
        .i0_stb(i0_stb), .i0_we(i0_we), .i0_sel(i0_sel), .i0_ack(i0_ack), .i0_err(i0_err),
        .i1_adr(i1_adr), .i1_dat_w(i1_dat_w), .i1_dat_r(i1_dat_r), .i1_cyc(i1_cyc),
        .i1_stb(i1_stb), .i1_we(i1_we), .i1_sel(i1_sel), .i1_ack(i1_ack), .i1_err(i1_err),
        .dma_req_i(dma_req_i), .dma_ack_o(dma_ack_o), .dma_nd_i(dma_nd_i),
        .dma_rest_i(dma_rest_i), .inta_o(inta_o), .intb_o(intb_o)
    );

    // Memories return an address-derived pattern so write data can be predicted
    assign i0_dat_r = i0_adr ^ 32'hA5A5_0000;
    assign i1_dat_r = i1_adr ^ 32'h5A5A_0000;

    always @(posedge clk) begin
        i0_ack <= 1'b0; i0_err <= 1'b0; i1_ack <= 1'b0; i1_err <= 1'b0;
        if (i0_cyc && i0_stb && !i0_ack && !i0_err) begin
            if (err_rd0 && !i0_we) begin
                i0_err <= 1'b1; err_rd0 <= 1'b0;
            end else i0_ack <= 1'b1;
            log_q.push_back('{1'b0, i0_we, i0_adr, i0_we ? i0_dat_w : i0_dat_r});
        end
        if (i1_cyc && i1_stb && !i1_ack && !i1_err) begin
            i1_ack <= 1'b1;
            log_q.push_back('{1'b1, i1_we, i1_adr, i1_we ? i1_dat_w : i1_dat_r});
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wb_access(input logic we, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] q);
        bit acked = 1'b0;
        @(negedge clk);
        rt_adr = a; rt_dat_w = d; rt_we = we; rt_cyc = 1'b1; rt_stb = 1'b1;
        q = 32'd0;
        for (int n = 0; n < 10 && !acked; n++) begin
            @(negedge clk);
            if (rt_ack) begin acked = 1'b1; q = rt_dat_r; end
        end
        rt_cyc = 1'b0; rt_stb = 1'b0; rt_we = 1'b0;
        if (!acked) check_eq("rt_ack_timeout", 0, 1);
    endtask

    task automatic reg_wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] q;
        wb_access(1'b1, a, d, q);
    endtask

    task automatic reg_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] q;
        wb_access(1'b0, a, 32'd0, q);
        check_eq(tag, q, exp);
    endtask

    task automatic wait_log(input string tag, input int n);
        int k = 0;
        while (log_q.size() < n && k < 2000) begin @(negedge clk); k++; end
        repeat (20) @(negedge clk);
        check_eq(tag, log_q.size(), n);
    endtask

    task automatic chk_x(input string tag, input int idx, input bit ifc, input bit we,
                         input logic [31:0] adr);
        if (idx < log_q.size())
            check_eq(tag, {ifc, we, adr}, {log_q[idx].ifc, log_q[idx].we, log_q[idx].adr});
        else check_eq(tag, idx, log_q.size());
    endtask

    task automatic wait_hw_ack(input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 600 && !seen; n++) begin
            @(negedge clk);
            if (dma_ack_o[2]) seen = 1'b1;
        end
        dma_req_i[2] = 1'b0;
        check_eq(tag, seen, 1);
        @(negedge clk);
        check_eq({tag, "_pulse"}, dma_ack_o, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_outs", {inta_o, intb_o, dma_ack_o, i0_cyc, i1_cyc, rt_ack}, 0);
        reg_chk("rst_ch0", 32'h20, 0);
        reg_chk("rst_ch1", 32'h40, 0);
        reg_chk("rst_ch2", 32'h60, 0);
        reg_chk("rst_ch3", 32'h80, 0);
        reg_chk("rst_int_src", 32'h0C, 0);
        reg_chk("rst_dbg", 32'h14, 0);

        // Software copy on ch0: i0 -> i1, both incrementing
        reg_wr(32'h00, 1); reg_wr(32'h04, 1);
        reg_wr(32'h24, 4); reg_wr(32'h28, 32'h1000); reg_wr(32'h2C, 32'h2000);
        reg_wr(32'h20, 32'h65);
        wait_log("cp_count", 8);
        for (int k = 0; k < 4; k++) begin
            chk_x("cp_rd", 2 * k, 1'b0, 1'b0, 32'h1000 + 32'(4 * k));
            chk_x("cp_wr", 2 * k + 1, 1'b1, 1'b1, 32'h2000 + 32'(4 * k));
            if (2 * k + 1 < log_q.size())
                check_eq("cp_data", log_q[2 * k + 1].dat, (32'h1000 + 32'(4 * k)) ^ 32'hA5A5_0000);
        end
        reg_chk("cp_csr", 32'h20, 32'h164);
        reg_chk("cp_int_src", 32'h0C, 1);
        check_eq("cp_irq", {inta_o, intb_o}, 2'b10);
        reg_wr(32'h0C, 32'hF);
        log_q.delete();

        // Handshake mode on ch2: total 8, chunk 4
        reg_wr(32'h64, 32'h0004_0008); reg_wr(32'h68, 32'h3000); reg_wr(32'h6C, 32'h4000);
        reg_wr(32'h60, 32'h69);
        repeat (20) @(negedge clk);
        check_eq("hw_idle_no_req", log_q.size(), 0);
        dma_req_i[2] = 1'b1;
        wait_hw_ack("hw_ack1");
        repeat (20) @(negedge clk);
        check_eq("hw_chunk1_cnt", log_q.size(), 8);
        reg_chk("hw_csr_mid", 32'h60, 32'h69);
        dma_req_i[2] = 1'b1;
        wait_hw_ack("hw_ack2");
        repeat (20) @(negedge clk);
        check_eq("hw_chunk2_cnt", log_q.size(), 16);
        chk_x("hw_last_wr", 15, 1'b0, 1'b1, 32'h401C);
        reg_chk("hw_csr_done", 32'h60, 32'h168);
        reg_chk("hw_int_src", 32'h0C, 4);
        reg_wr(32'h0C, 32'hF);
        log_q.delete();

        // Priority: ch1 and ch3 released together, ch1 wins its whole chunk
        reg_wr(32'h00, 0);
        reg_wr(32'h44, 32'h0002_0002); reg_wr(32'h48, 32'h5000); reg_wr(32'h4C, 32'h5100);
        reg_wr(32'h84, 32'h0002_0002); reg_wr(32'h88, 32'h6000); reg_wr(32'h8C, 32'h6100);
        reg_wr(32'h40, 32'h61); reg_wr(32'h80, 32'h61);
        reg_wr(32'h00, 1);
        wait_log("pri_count", 8);
        chk_x("pri_0", 0, 1'b0, 1'b0, 32'h5000);
        chk_x("pri_1", 1, 1'b0, 1'b1, 32'h5100);
        chk_x("pri_2", 2, 1'b0, 1'b0, 32'h5004);
        chk_x("pri_3", 3, 1'b0, 1'b1, 32'h5104);
        chk_x("pri_4", 4, 1'b0, 1'b0, 32'h6000);
        chk_x("pri_7", 7, 1'b0, 1'b1, 32'h6104);
        reg_chk("pri_int_src", 32'h0C, 32'hA);
        reg_wr(32'h0C, 32'hF);
        log_q.delete();

        // Read error on ch0
        err_rd0 = 1'b1;
        reg_wr(32'h24, 4); reg_wr(32'h28, 32'h1000);
        reg_wr(32'h20, 32'h65);
        wait_log("err_no_write", 1);
        reg_chk("err_csr", 32'h20, 32'h264);
        reg_chk("err_int_src", 32'h0C, 1);
        check_eq("err_inta", inta_o, 1);
        reg_wr(32'h0C, 32'hF);
        log_q.delete();

        // Auto-restart on ch0: second pass repeats the original addresses
        reg_wr(32'h24, 2); reg_wr(32'h28, 32'h7000); reg_wr(32'h2C, 32'h7100);
        reg_wr(32'h20, 32'h75);
        begin
            int k = 0;
            while (log_q.size() < 8 && k < 2000) begin @(negedge clk); k++; end
        end
        reg_wr(32'h00, 0);
        repeat (30) @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            chk_x("ars_rd0", 4 * p, 1'b0, 1'b0, 32'h7000);
            chk_x("ars_wr0", 4 * p + 1, 1'b1, 1'b1, 32'h7100);
            chk_x("ars_rd1", 4 * p + 2, 1'b0, 1'b0, 32'h7004);
            chk_x("ars_wr1", 4 * p + 3, 1'b1, 1'b1, 32'h7104);
        end
        reg_chk("ars_csr", 32'h20, 32'h175);
        reg_chk("ars_int_src", 32'h0C, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
